// File: rtl/gauss_pkg.sv
// Shared definitions for the 3x3 Gaussian blur engine.
//
// Contents:
//   gauss_state_t  - sequencer states
//   CTRL_START_BIT - bit of the control register word that starts a run
//   ACC_W          - accumulator width (16 * 255 = 4080 fits in 12 bits)
//   TAP_W/LAST_TAP - tap counter width and index of the final interior tap
//   weight()       - kernel weight of a row-major tap index
//
// Design option macro: GAUSS_ROUND_EN (used by gauss_filter_engine).

package gauss_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAST,
        WRITE,
        DONE
    } gauss_state_t;

    localparam int CTRL_START_BIT = 0;
    localparam int ACC_W          = 12;
    localparam int TAP_W          = 4;

    localparam logic [TAP_W-1:0] LAST_TAP = 4'd8;

    // Kernel 1 2 1 / 2 4 2 / 1 2 1 in row-major tap order: the centre tap
    // is 4, edge-adjacent taps (odd indices) are 2, corners are 1.
    function automatic logic [2:0] weight(input logic [TAP_W-1:0] tap);
        if (tap == 4'd4) begin
            return 3'd4;
        end else if (tap[0]) begin
            return 3'd2;
        end else begin
            return 3'd1;
        end
    endfunction

endpackage

// File: rtl/gauss_filter_engine_addr_gen.sv
// Combinational address generator for the Gaussian blur engine.
//
// Maps the current pixel (x, y) and tap index onto a source RAM address,
// and also produces the pixel's own linear offset y*IMG_W + x that the
// top level uses for the destination address.
//
// Ports:
//   x, y      - current pixel coordinates
//   tap       - row-major tap index 0..8 within the 3x3 window
//   border    - pixel lies on the image edge; its single tap is itself
//   tap_addr  - SRC_BASE + row*IMG_W + col for the selected tap
//   pix_off   - y*IMG_W + x (no base added)

module gauss_filter_engine_addr_gen
    import gauss_pkg::*;
#(
    parameter int IMG_W    = 16,
    parameter int ADDR_W   = 10,
    parameter int SRC_BASE = 0,
    parameter int XW       = 4,
    parameter int YW       = 4
) (
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [TAP_W-1:0]  tap,
    input  logic              border,
    output logic [ADDR_W-1:0] tap_addr,
    output logic [ADDR_W-1:0] pix_off
);

    logic [1:0]        drow;
    logic [1:0]        dcol;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    // Split the tap index into a window row/column (0..2 each). Interior
    // pixels have x>=1 and y>=1, so subtracting 1 never underflows.
    always_comb begin
        drow = 2'd0;
        dcol = 2'd0;
        case (tap)
            4'd0: begin drow = 2'd0; dcol = 2'd0; end
            4'd1: begin drow = 2'd0; dcol = 2'd1; end
            4'd2: begin drow = 2'd0; dcol = 2'd2; end
            4'd3: begin drow = 2'd1; dcol = 2'd0; end
            4'd4: begin drow = 2'd1; dcol = 2'd1; end
            4'd5: begin drow = 2'd1; dcol = 2'd2; end
            4'd6: begin drow = 2'd2; dcol = 2'd0; end
            4'd7: begin drow = 2'd2; dcol = 2'd1; end
            4'd8: begin drow = 2'd2; dcol = 2'd2; end
            default: begin drow = 2'd1; dcol = 2'd1; end
        endcase

        if (border) begin
            row = ADDR_W'(y);
            col = ADDR_W'(x);
        end else begin
            row = ADDR_W'(y) + ADDR_W'(drow) - ADDR_W'(1);
            col = ADDR_W'(x) + ADDR_W'(dcol) - ADDR_W'(1);
        end

        tap_addr = ADDR_W'(SRC_BASE) + row * ADDR_W'(IMG_W) + col;
        pix_off  = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
    end

endmodule

// File: rtl/gauss_filter_engine.sv
// 3x3 Gaussian blur engine (kernel 1 2 1 / 2 4 2 / 1 2 1, divided by 16).
//
// Walks an IMG_W x IMG_H 8-bit image in raster order, reading taps from a
// source RAM (1-cycle read latency) and writing one result per pixel into
// a destination RAM. Edge pixels are copied unchanged. When the image is
// done, a one-cycle status write clears the start bit in the control
// register.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   ctrl_word    - control register contents, bit 0 = start (level sensed)
//   stat_we      - one-cycle status write strobe (DONE state)
//   stat_bit     - status value written, always 0
//   src_addr     - source RAM read address (holds outside READ)
//   src_rd_data  - source RAM data, valid one cycle after src_addr
//   dst_addr     - destination RAM write address
//   dst_wr_data  - destination write data
//   dst_we       - destination write enable (WRITE state only)
//   busy         - high from the first READ cycle through DONE
//
// Design option macro: GAUSS_ROUND_EN
//   defined   - interior result = (acc + 8) >> 4 (round half up)
//   undefined - interior result = acc >> 4 (truncate)

module gauss_filter_engine
    import gauss_pkg::*;
#(
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int ADDR_W   = 10,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ctrl_word,
    output logic              stat_we,
    output logic              stat_bit,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_rd_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [7:0]        dst_wr_data,
    output logic              dst_we,
    output logic              busy
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    gauss_state_t state, state_n;

    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [TAP_W-1:0]  tap, tap_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic [ADDR_W-1:0] src_addr_q, src_addr_n;

    logic              border;
    logic [ADDR_W-1:0] tap_addr;
    logic [ADDR_W-1:0] pix_off;
    logic [TAP_W-1:0]  data_tap;
    logic [2:0]        cur_w;
    logic [ACC_W-1:0]  product;
    logic [7:0]        interior_pix;
    logic              unused_ctrl;

    assign unused_ctrl = ^ctrl_word[31:1];

    assign border = (x == '0) || (y == '0) || (x == X_MAX) || (y == Y_MAX);

    gauss_filter_engine_addr_gen #(
        .IMG_W    (IMG_W),
        .ADDR_W   (ADDR_W),
        .SRC_BASE (SRC_BASE),
        .XW       (XW),
        .YW       (YW)
    ) u_addr_gen (
        .x        (x),
        .y        (y),
        .tap      (tap),
        .border   (border),
        .tap_addr (tap_addr),
        .pix_off  (pix_off)
    );

    // The RAM answers one cycle late: in READ the data on src_rd_data
    // belongs to tap-1, in LAST it belongs to the final tap itself.
    always_comb begin
        data_tap = (state == LAST) ? tap : tap - 4'd1;
        cur_w    = border ? 3'd1 : weight(data_tap);
        product  = ACC_W'(src_rd_data) * ACC_W'(cur_w);
    end

    // Divide by 16; the rounded form tops out at (4080 + 8) >> 4 = 255.
    always_comb begin
`ifdef GAUSS_ROUND_EN
        interior_pix = 8'((acc + ACC_W'(8)) >> 4);
`else
        interior_pix = 8'(acc >> 4);
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            tap        <= '0;
            acc        <= '0;
            src_addr_q <= '0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            tap        <= tap_n;
            acc        <= acc_n;
            src_addr_q <= src_addr_n;
        end
    end

    // Next-state and datapath update. Border pixels take a single tap, so
    // READ goes straight to LAST with tap still 0.
    always_comb begin
        state_n    = state;
        x_n        = x;
        y_n        = y;
        tap_n      = tap;
        acc_n      = acc;
        src_addr_n = src_addr_q;

        case (state)
            IDLE: begin
                if (ctrl_word[CTRL_START_BIT]) begin
                    x_n     = '0;
                    y_n     = '0;
                    tap_n   = '0;
                    acc_n   = '0;
                    state_n = READ;
                end
            end

            READ: begin
                src_addr_n = tap_addr;
                if (tap != '0) begin
                    acc_n = acc + product;
                end
                if (border || (tap == LAST_TAP)) begin
                    state_n = LAST;
                end else begin
                    tap_n = tap + 4'd1;
                end
            end

            LAST: begin
                acc_n   = acc + product;
                state_n = WRITE;
            end

            WRITE: begin
                acc_n   = '0;
                tap_n   = '0;
                state_n = READ;
                if (x == X_MAX) begin
                    x_n = '0;
                    if (y == Y_MAX) begin
                        state_n = DONE;
                    end else begin
                        y_n = y + 1'b1;
                    end
                end else begin
                    x_n = x + 1'b1;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state; the source address is live in
    // READ and otherwise repeats the last address issued.
    assign src_addr    = (state == READ) ? tap_addr : src_addr_q;
    assign busy        = (state != IDLE);
    assign dst_we      = (state == WRITE);
    assign dst_addr    = dst_we ? (ADDR_W'(DST_BASE) + pix_off) : '0;
    assign dst_wr_data = dst_we ? (border ? acc[7:0] : interior_pix) : 8'd0;
    assign stat_we     = (state == DONE);
    assign stat_bit    = 1'b0;

endmodule

// File: tb/tb_gauss_filter_engine.sv
// Directed self-checking bench for gauss_filter_engine on a 4x4 image with
// non-zero RAM bases. Models the source RAM (1-cycle read), destination
// RAM and the control register (CPU write beats status write).

module tb_gauss_filter_engine;

    localparam int IMG_W    = 4;
    localparam int IMG_H    = 4;
    localparam int ADDR_W   = 6;
    localparam int SRC_BASE = 8;
    localparam int DST_BASE = 20;
    localparam int NPIX     = IMG_W * IMG_H;

`ifdef GAUSS_ROUND_EN
    localparam int T4_EXP = 2;
`else
    localparam int T4_EXP = 1;
`endif

    logic              clk;
    logic              rst;
    logic [31:0]       ctrl_word;
    logic              stat_we;
    logic              stat_bit;
    logic [ADDR_W-1:0] src_addr;
    logic [7:0]        src_rd_data;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        dst_wr_data;
    logic              dst_we;
    logic              busy;

    logic              cpu_we;
    logic [31:0]       cpu_data;
    logic              dst_clear;

    logic [7:0]        src_mem [64];
    logic [7:0]        dst_mem [64];
    logic [7:0]        img [NPIX];

    int vectors;
    int miscompares;
    int stat_cnt;
    int wr_cnt;
    int busy_cycles;

    gauss_filter_engine #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .ADDR_W   (ADDR_W),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_word   (ctrl_word),
        .stat_we     (stat_we),
        .stat_bit    (stat_bit),
        .src_addr    (src_addr),
        .src_rd_data (src_rd_data),
        .dst_addr    (dst_addr),
        .dst_wr_data (dst_wr_data),
        .dst_we      (dst_we),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM with one cycle of read latency.
    always @(posedge clk) src_rd_data <= src_mem[src_addr];

    // Destination RAM; dst_clear fills it with a sentinel between runs.
    always @(posedge clk) begin
        if (dst_clear) begin
            for (int i = 0; i < 64; i++) dst_mem[i] <= 8'hA5;
        end else if (dst_we) begin
            dst_mem[dst_addr] <= dst_wr_data;
        end
    end

    // Control register: a CPU write wins over the engine's status write.
    always @(posedge clk) begin
        if (rst) begin
            ctrl_word <= 32'd0;
        end else if (cpu_we) begin
            ctrl_word <= cpu_data;
        end else if (stat_we) begin
            ctrl_word[0] <= stat_bit;
        end
    end

    // Event counters read as before/after snapshots.
    initial begin
        stat_cnt    = 0;
        wr_cnt      = 0;
        busy_cycles = 0;
    end
    always @(posedge clk) begin
        if (stat_we) stat_cnt <= stat_cnt + 1;
        if (dst_we) wr_cnt <= wr_cnt + 1;
        if (busy && !stat_we) busy_cycles <= busy_cycles + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One CPU write to the control register.
    task automatic applyStimulus(input logic [31:0] value);
        @(negedge clk);
        cpu_data = value;
        cpu_we   = 1'b1;
        @(negedge clk);
        cpu_we   = 1'b0;
    endtask

    // Reference blur: straightforward 2D convolution over the tb image.
    function automatic int golden(input int px, input int py);
        int sum;
        if (px == 0 || py == 0 || px == IMG_W - 1 || py == IMG_H - 1)
            return int'(img[py * IMG_W + px]);
        sum = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                sum += int'(img[(py + dy) * IMG_W + (px + dx)])
                       * ((dy == 0) ? 2 : 1) * ((dx == 0) ? 2 : 1);
            end
        end
`ifdef GAUSS_ROUND_EN
        return (sum + 8) >> 4;
`else
        return sum >> 4;
`endif
    endfunction

    task automatic fill_image(input logic [7:0] v);
        for (int i = 0; i < NPIX; i++) begin
            img[i]                = v;
            src_mem[SRC_BASE + i] = v;
        end
    endtask

    task automatic set_pix(input int px, input int py, input logic [7:0] v);
        img[py * IMG_W + px]                = v;
        src_mem[SRC_BASE + py * IMG_W + px] = v;
    endtask

    task automatic clear_dst();
        @(negedge clk);
        dst_clear = 1'b1;
        @(negedge clk);
        dst_clear = 1'b0;
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < NPIX; i++) begin
            checkOutput($sformatf("%s_dst%0d", tag, i),
                        {24'd0, dst_mem[DST_BASE + i]},
                        golden(i % IMG_W, i / IMG_W));
        end
    endtask

    // Waits for the DONE strobe within a cycle budget. With rearm set, the
    // CPU rewrites start=1 during the DONE cycle.
    task automatic wait_done(input string tag, input bit rearm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (stat_we) begin
                ok = 1'b1;
                checkOutput({tag, "_stat_bit"}, {31'd0, stat_bit}, 32'd0);
                if (rearm) begin
                    cpu_data = 32'd1;
                    cpu_we   = 1'b1;
                end
                break;
            end
        end
        checkOutput({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int s0, w0, b0;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cpu_we      = 1'b0;
        cpu_data    = 32'd0;
        dst_clear   = 1'b0;
        for (int i = 0; i < 64; i++) src_mem[i] = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_stat_we", {31'd0, stat_we}, 32'd0);
        checkOutput("rst_dst_we", {31'd0, dst_we}, 32'd0);
        checkOutput("rst_src_addr", {26'd0, src_addr}, 32'd0);
        checkOutput("rst_dst_addr", {26'd0, dst_addr}, 32'd0);
        checkOutput("rst_dst_data", {24'd0, dst_wr_data}, 32'd0);

        // 1: flat image, timing and single status pulse
        fill_image(8'd100);
        clear_dst();
        s0 = stat_cnt; w0 = wr_cnt; b0 = busy_cycles;
        applyStimulus(32'd1);
        wait_done("t1", 1'b0);
        @(negedge clk);
        checkOutput("t1_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("t1_stat_we_after", {31'd0, stat_we}, 32'd0);
        checkOutput("t1_start_cleared", {31'd0, ctrl_word[0]}, 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t1_no_rerun", {31'd0, busy}, 32'd0);
        checkOutput("t1_cycles", busy_cycles - b0, 32'd80);
        checkOutput("t1_stat_pulses", stat_cnt - s0, 32'd1);
        checkOutput("t1_writes", wr_cnt - w0, 32'd16);
        for (int i = 0; i < NPIX; i++)
            checkOutput($sformatf("t1_flat%0d", i), {24'd0, dst_mem[DST_BASE + i]}, 32'd100);

        // 2: single bright interior pixel
        fill_image(8'd0);
        set_pix(1, 1, 8'd160);
        clear_dst();
        applyStimulus(32'd1);
        wait_done("t2", 1'b0);
        @(negedge clk);
        checkOutput("t2_p11", {24'd0, dst_mem[DST_BASE + 5]}, 32'd40);
        checkOutput("t2_p21", {24'd0, dst_mem[DST_BASE + 6]}, 32'd20);
        checkOutput("t2_p12", {24'd0, dst_mem[DST_BASE + 9]}, 32'd20);
        checkOutput("t2_p22", {24'd0, dst_mem[DST_BASE + 10]}, 32'd10);
        check_image("t2");

        // 3: saturated window, acc = 4080
        fill_image(8'd0);
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < 3; xx++)
                set_pix(xx, yy, 8'd255);
        clear_dst();
        applyStimulus(32'd1);
        wait_done("t3", 1'b0);
        @(negedge clk);
        checkOutput("t3_p11_max", {24'd0, dst_mem[DST_BASE + 5]}, 32'd255);
        check_image("t3");

        // 4: acc = 24 at (1,1), rounding boundary
        fill_image(8'd0);
        set_pix(1, 1, 8'd6);
        clear_dst();
        applyStimulus(32'd1);
        wait_done("t4", 1'b0);
        @(negedge clk);
        checkOutput("t4_p11_round", {24'd0, dst_mem[DST_BASE + 5]}, T4_EXP);
        check_image("t4");

        // 5: reset mid-run, then a full clean run
        for (int i = 0; i < NPIX; i++) begin
            img[i]                = 8'((i * 37 + 11) % 256);
            src_mem[SRC_BASE + i] = img[i];
        end
        clear_dst();
        applyStimulus(32'd1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s0 = stat_cnt; w0 = wr_cnt;
        checkOutput("t5_busy_rst", {31'd0, busy}, 32'd0);
        checkOutput("t5_dst_we_rst", {31'd0, dst_we}, 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("t5_no_stat", stat_cnt - s0, 32'd0);
        checkOutput("t5_no_writes", wr_cnt - w0, 32'd0);
        checkOutput("t5_idle", {31'd0, busy}, 32'd0);
        clear_dst();
        applyStimulus(32'd1);
        wait_done("t5", 1'b0);
        @(negedge clk);
        check_image("t5");

        // 6: start toggled mid-run, then re-armed in the DONE cycle
        clear_dst();
        s0 = stat_cnt; b0 = busy_cycles;
        applyStimulus(32'd1);
        repeat (15) @(negedge clk);
        applyStimulus(32'd0);
        repeat (15) @(negedge clk);
        applyStimulus(32'd1);
        wait_done("t6a", 1'b1);
        @(negedge clk);
        cpu_we = 1'b0;
        checkOutput("t6_rearmed", {31'd0, ctrl_word[0]}, 32'd1);
        checkOutput("t6a_cycles", busy_cycles - b0, 32'd80);
        check_image("t6a");
        clear_dst();
        wait_done("t6b", 1'b0);
        @(negedge clk);
        repeat (10) @(negedge clk);
        checkOutput("t6_single_rerun", {31'd0, busy}, 32'd0);
        checkOutput("t6_stat_pulses", stat_cnt - s0, 32'd2);
        checkOutput("t6b_cycles", busy_cycles - b0, 32'd160);
        check_image("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gauss_filter_engine.md
Name: gauss_filter_engine

Overview:
Consumer of the Gauss control register word; the register's 32-bit output feeds ctrl_word. When start (ctrl_word[0]) is seen, the block runs a 3x3 Gaussian blur (kernel 1 2 1 / 2 4 2 / 1 2 1, divided by 16) over an 8-bit image. It reads from a source pixel RAM and writes to a destination pixel RAM. On completion it writes status back to the control register to clear start, which the CPU polls.

Parameters:
IMG_W, 16, image width in pixels (>=3)
IMG_H, 16, image height in pixels (>=3)
ADDR_W, 10, pixel address width; 2**ADDR_W >= IMG_W*IMG_H
SRC_BASE, 0, source RAM base address
DST_BASE, 0, destination RAM base address

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ctrl_word  input  32  control register contents; bit0 = start, other bits ignored
stat_we  output  1  one-cycle status write strobe to control register
stat_bit  output  1  status value written (always 0 = start cleared)
src_addr  output  ADDR_W  source RAM read address
src_rd_data  input  8  source RAM data, valid 1 cycle after src_addr
dst_addr  output  ADDR_W  destination RAM write address
dst_wr_data  output  8  destination write data
dst_we  output  1  destination write enable
busy  output  1  high from first READ cycle through DONE

Behaviour:
- Reset and interface: clk clock; rst synchronous, active-high. Reset clears all outputs and x, y, tap counter and accumulator to 0, and puts the FSM in IDLE. Reset mid-run aborts with no stat_we and no further dst_we.
- States: IDLE, READ, LAST, WRITE, DONE.
- IDLE: busy=0. If ctrl_word[0]=1, load x=0, y=0, tap=0, acc=0 and go to READ. The start bit is level-sensed.
- Pixel classes: border pixel = x==0, y==0, x==IMG_W-1 or y==IMG_H-1; it uses 1 tap. Interior pixel uses 9 taps, row-major from (x-1,y-1) to (x+1,y+1).
- Addressing: tap address = SRC_BASE + row*IMG_W + col. Border tap = own address.
- READ: drive the tap address. The data for the previous tap arrives this cycle; accumulate it as acc += src_rd_data * weight (weight 1, 2 or 4). Weight = 1 for border pixels. Advance tap. After the final tap go to LAST.
- LAST: accumulate the final tap, then go to WRITE.
- WRITE: dst_we=1, dst_addr = DST_BASE + y*IMG_W + x.
  - dst_wr_data = src pixel for border pixels.
  - dst_wr_data = acc[11:4] for interior pixels.
  - Then advance x; at x=IMG_W-1, wrap x=0 and y++. Clear acc and tap.
  - After the last pixel go to DONE, otherwise go to READ.
- Latency: interior pixel = exactly 11 cycles (9 READ + LAST + WRITE); border pixel = 3 cycles. A 16x16 image takes 60*3 + 196*11 = 2336 cycles, plus 1 DONE cycle.
- Accumulator: 12 bits unsigned; max 16*255 = 4080, so it cannot overflow.
- DONE: stat_we=1, stat_bit=0 for exactly one cycle, busy=1, then go to IDLE. The register clears bit0 on the same edge, so IDLE never re-triggers spuriously.
- Simultaneous events:
  - ctrl_word changes while busy are ignored, including start 1->0. The run always completes.
  - A CPU write in the DONE cycle takes priority in the register. If it sets bit0, a new run starts from IDLE on the following cycle.
- dst_we is high only in WRITE. src_addr holds its last value outside READ.

Optional Feature:
GAUSS_ROUND_EN
- Defined: interior result = (acc + 8) >> 4, round-half-up; max (4080+8)>>4 = 255, so no saturation is needed.
- Undefined: result = acc >> 4, truncation.
- Border pixels are unaffected either way.

Decomposition:
- Package gauss_pkg:
  - state enum gauss_state_t {IDLE, READ, LAST, WRITE, DONE};
  - CTRL_START_BIT = 0;
  - ACC_W = 12;
  - kernel weight function weight(tap) returning 1, 2 or 4.
- One sub-module, gauss_addr_gen: combinational tap-to-address mapping from x, y, tap and the border flag. It isolates the multiply-by-IMG_W arithmetic.

Test Plan:
1. IMG_W=IMG_H=4, all src=100, start=1 -> all 16 dst=100; stat_we pulses once, 80 cycles after start, with stat_bit=0; busy low afterwards.
2. 4x4, src=0 except (1,1)=160 -> dst(1,1)=40, dst(2,1)=20, dst(1,2)=20, dst(2,2)=10; border pixels keep their src values.
3. 4x4, interior taps for dst(1,1) = 255 each -> acc=4080, dst(1,1)=255 with and without GAUSS_ROUND_EN.
4. Taps giving acc=24 -> dst=1 without GAUSS_ROUND_EN, 2 with it.
5. Assert rst at cycle 30 of a run -> no stat_we, dst_we stops, busy=0; restarting with start=1 yields full correct output.
6. Toggle ctrl_word[0] to 0 then 1 mid-run -> run unaffected, single stat_we; start held at 1 through DONE -> exactly one new run begins.
